// File: rtl/serial_receiver.sv
// serial_receiver
//   Consumer end of a 1-bit buffered serial line. Frames are one start bit
//   (0), WIDTH data bits LSB first, then one stop bit (1); the idle line is 1.
//   The line is sampled only on clocks where the bit strobe en is high.
//   Good frames update s and pulse valid for one cycle. A stop bit sampled
//   as 0 pulses err for one cycle and parks the FSM in BREAK until the line
//   returns high, so a stuck-low line is not read as repeated start bits.
// Ports
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous, active-high
//   en     : bit strobe, p is sampled only when en=1
//   p      : serial line input (idle = 1)
//   s      : last correctly received word
//   valid  : one-cycle pulse, s updated with a new word
//   err    : one-cycle pulse, stop bit sampled as 0
//   busy   : 1 while the FSM is not IDLE
module serial_receiver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             p,
  output logic [WIDTH-1:0] s,
  output logic             valid,
  output logic             err,
  output logic             busy
);

  // Counter is wide enough to hold WIDTH, so the increment after the last
  // data bit never wraps.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2,
    BREAK = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      shift <= '0;
      s     <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      // Pulses last exactly one cycle regardless of en.
      valid <= 1'b0;
      err   <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (!p) begin
              state <= DATA;
              cnt   <= '0;
            end
          end
          DATA: begin
            // Decoded write keeps the index width-matched to shift.
            for (int i = 0; i < WIDTH; i++)
              if (cnt == CW'(i)) shift[i] <= p;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= STOP;
          end
          STOP: begin
            if (p) begin
              s     <= shift;
              valid <= 1'b1;
              state <= IDLE;
            end else begin
              err   <= 1'b1;
              state <= BREAK;
            end
          end
          BREAK: begin
            if (p) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_receiver.sv
module tb_serial_receiver;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             p;
  logic [WIDTH-1:0] s;
  logic             valid;
  logic             err;
  logic             busy;

  int nvec = 0;
  int nbad = 0;
  int cyc  = 0;
  int t0;

  serial_receiver #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .p     (p),
    .s     (s),
    .valid (valid),
    .err   (err),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are read 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // gap-1 clocks with en=0 (line driven to the opposite value, which must
  // be ignored), then one clock with en=1 sampling b.
  task automatic strobe(input logic b, input int gap);
    for (int i = 1; i < gap; i++) begin
      en = 1'b0;
      p  = ~b;
      tick;
    end
    en = 1'b1;
    p  = b;
    tick;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] d, input logic stop, input int gap);
    strobe(1'b0, gap);
    for (int i = 0; i < WIDTH; i++) strobe(d[i], gap);
    strobe(stop, gap);
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    p     = 1'b1;

    // 1: reset state
    tick; tick;
    chk("rst_s", 32'(s), 32'h0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    strobe(1'b1, 1);
    chk("idle_busy", 32'(busy), 0);

    // 2: single frame A5
    strobe(1'b0, 1);
    chk("a5_busy_start", 32'(busy), 1);
    for (int i = 0; i < WIDTH; i++) strobe(1'(8'hA5 >> i), 1);
    chk("a5_pre_valid", 32'(valid), 0);
    chk("a5_pre_s", 32'(s), 32'h0);
    strobe(1'b1, 1);
    chk("a5_valid", 32'(valid), 1);
    chk("a5_s", 32'(s), 32'hA5);
    chk("a5_err", 32'(err), 0);
    chk("a5_busy_end", 32'(busy), 0);
    strobe(1'b1, 1);
    chk("a5_valid_fall", 32'(valid), 0);

    // 3: back-to-back 3C, C3
    send_frame(8'h3C, 1'b1, 1);
    chk("3c_valid", 32'(valid), 1);
    chk("3c_s", 32'(s), 32'h3C);
    t0 = cyc;
    strobe(1'b0, 1);
    chk("b2b_start_busy", 32'(busy), 1);
    chk("b2b_valid_fall", 32'(valid), 0);
    for (int i = 0; i < WIDTH; i++) strobe(1'(8'hC3 >> i), 1);
    strobe(1'b1, 1);
    chk("c3_valid", 32'(valid), 1);
    chk("c3_s", 32'(s), 32'hC3);
    chk("c3_spacing", 32'(cyc - t0), 10);

    // 4: bad stop bit then stuck-low line
    send_frame(8'hFF, 1'b0, 1);
    chk("ff_err", 32'(err), 1);
    chk("ff_valid", 32'(valid), 0);
    chk("ff_s_hold", 32'(s), 32'hC3);
    chk("ff_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      strobe(1'b0, 1);
      chk("brk_busy", 32'(busy), 1);
      chk("brk_err_fall", 32'(err), 0);
    end
    strobe(1'b1, 1);
    chk("brk_exit", 32'(busy), 0);
    strobe(1'b1, 1);
    chk("brk_no_start", 32'(busy), 0);
    chk("brk_s_hold", 32'(s), 32'hC3);

    // 5: strobe every 3rd clock, line toggled on idle clocks
    t0 = cyc;
    send_frame(8'h81, 1'b1, 3);
    chk("81_valid", 32'(valid), 1);
    chk("81_s", 32'(s), 32'h81);
    chk("81_clocks", 32'(cyc - t0), 30);
    en = 1'b0;
    p  = 1'b0;
    tick;
    chk("81_valid_fall", 32'(valid), 0);
    chk("81_en0_no_start", 32'(busy), 0);

    // 6: reset after data bit 4 of 55, then full 0F frame
    strobe(1'b0, 1);
    for (int i = 0; i < 5; i++) strobe(1'(8'h55 >> i), 1);
    reset = 1'b1;
    p     = 1'b1;
    tick;
    chk("abort_valid", 32'(valid), 0);
    chk("abort_err", 32'(err), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_s", 32'(s), 32'h0);
    reset = 1'b0;
    send_frame(8'h0F, 1'b1, 1);
    chk("0f_valid", 32'(valid), 1);
    chk("0f_s", 32'(s), 32'h0F);
    chk("0f_err", 32'(err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
